// File: rtl/mem_arb_pkg.sv
// Shared definitions for the unified memory arbiter.
//   arb_state_t : FSM state encoding (IDLE / WAIT / RESP)
//   OWN_IF/LS   : requester IDs; also the bit positions in the picker request vector
//   MEM_LAT_MAX : largest supported memory latency; sizes the wait counter
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_LS = 1'b1;

  localparam int unsigned MEM_LAT_MAX = 8;
  localparam int unsigned CNT_W       = $clog2(MEM_LAT_MAX);

endpackage

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the arbiter, its two requesters (fetch, load/store) and
// the single-port memory.
//   master : arbiter view (drives gnt/rvalid/rdata and the memory command)
//   slave  : environment view (requesters and memory)
interface mem_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  // fetch requester
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;
  // load/store requester
  logic                ls_req;
  logic                ls_we;
  logic [DATA_W/8-1:0] ls_be;
  logic [ADDR_W-1:0]   ls_addr;
  logic [DATA_W-1:0]   ls_wdata;
  logic                ls_gnt;
  logic                ls_rvalid;
  logic [DATA_W-1:0]   ls_rdata;
  // memory port
  logic                mem_en;
  logic [DATA_W/8-1:0] mem_we;
  logic [ADDR_W-1:0]   mem_addr;
  logic [DATA_W-1:0]   mem_wdata;
  logic [DATA_W-1:0]   mem_rdata;

  modport master (
    input  if_req, if_addr,
    output if_gnt, if_rvalid, if_rdata,
    input  ls_req, ls_we, ls_be, ls_addr, ls_wdata,
    output ls_gnt, ls_rvalid, ls_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport slave (
    output if_req, if_addr,
    input  if_gnt, if_rvalid, if_rdata,
    output ls_req, ls_we, ls_be, ls_addr, ls_wdata,
    input  ls_gnt, ls_rvalid, ls_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/mem_arbiter_rr_pick2.sv
// Combinational 2-way round-robin picker.
//   req[OWN_IF], req[OWN_LS] : request lines
//   last                      : ID of the previous winner
//   gvalid                    : at least one request present
//   winner                    : ID of the selected requester
module rr_pick2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic       gvalid,
  output logic       winner
);

  always_comb begin
    gvalid = |req;
    winner = OWN_IF;
    case (req)
      2'b01:   winner = OWN_IF;
      2'b10:   winner = OWN_LS;
      2'b11:   winner = ~last;   // contention: whoever did not win last time
      default: winner = OWN_IF;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter for the unified single-port instruction/data memory shared by the
// fetch unit (IF) and the load/store unit (LS). One transaction outstanding at
// a time; response returned MEM_LAT cycles after the grant.
//   clk  : rising-edge clock
//   rst  : synchronous, active-low reset
//   bus  : requester handshakes and memory port (mem_arbiter_if.master)
//   busy : a transaction is outstanding
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned MEM_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.master bus,
  output logic          busy
);

  if (MEM_LAT < 1 || MEM_LAT > MEM_LAT_MAX) begin : g_lat_check
    $error("mem_arbiter: MEM_LAT out of range 1..8");
  end

  localparam logic [CNT_W-1:0] CNT_INIT = (MEM_LAT > 1) ? CNT_W'(MEM_LAT - 2) : '0;

  arb_state_t        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic              last_q;
  logic              owner_q;
  logic              store_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] if_rdata_q;
  logic [DATA_W-1:0] ls_rdata_q;

  logic gvalid;
  logic winner;
  logic grant;
  logic resp;

  rr_pick2 u_pick (
    .req    ({bus.ls_req, bus.if_req}),
    .last   (last_q),
    .gvalid (gvalid),
    .winner (winner)
  );

  assign grant = rst && (state_q == IDLE) && gvalid;
  assign resp  = rst && (state_q == RESP);
  assign busy  = (state_q != IDLE);

  // State register
  always_ff @(posedge clk) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant) state_d = (MEM_LAT > 1) ? WAIT : RESP;
      WAIT:    if (cnt_q == '0) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    bus.if_gnt    = grant && (winner == OWN_IF);
    bus.ls_gnt    = grant && (winner == OWN_LS);
    bus.mem_en    = grant;
    bus.mem_we    = (grant && (winner == OWN_LS) && bus.ls_we) ? bus.ls_be : '0;
    bus.mem_addr  = addr_q;
    bus.mem_wdata = wdata_q;
    if (grant) begin
      bus.mem_addr  = (winner == OWN_LS) ? bus.ls_addr : bus.if_addr;
      bus.mem_wdata = (winner == OWN_LS) ? bus.ls_wdata : '0;
    end
    bus.if_rvalid = resp && (owner_q == OWN_IF);
    bus.ls_rvalid = resp && (owner_q == OWN_LS);
    // Read data is forwarded from mem_rdata in the RESP cycle and held in a
    // register afterwards, so the value stays stable between pulses.
    bus.if_rdata  = bus.if_rvalid ? bus.mem_rdata : if_rdata_q;
    bus.ls_rdata  = bus.ls_rvalid ? (store_q ? '0 : bus.mem_rdata) : ls_rdata_q;
  end

  // Transaction bookkeeping and held outputs.
  // last_q holds the previous winner; resetting it to IF makes LS go first.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q      <= '0;
      last_q     <= OWN_IF;
      owner_q    <= OWN_IF;
      store_q    <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      if_rdata_q <= '0;
      ls_rdata_q <= '0;
    end else begin
      if (grant) begin
        last_q  <= winner;
        owner_q <= winner;
        store_q <= (winner == OWN_LS) && bus.ls_we;
        addr_q  <= bus.mem_addr;
        wdata_q <= bus.mem_wdata;
        cnt_q   <= CNT_INIT;
      end else if (state_q == WAIT && cnt_q != '0) begin
        cnt_q <= cnt_q - 1'b1;
      end
      if (bus.if_rvalid) if_rdata_q <= bus.if_rdata;
      if (bus.ls_rvalid) ls_rdata_q <= bus.ls_rdata;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic rst;
  logic busy1, busy2, busy3, busy4;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b1 ();
  mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b2 ();
  mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b3 ();
  mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b4 ();

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) d1 (.clk(clk), .rst(rst), .bus(b1.master), .busy(busy1));
  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(2)) d2 (.clk(clk), .rst(rst), .bus(b2.master), .busy(busy2));
  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(3)) d3 (.clk(clk), .rst(rst), .bus(b3.master), .busy(busy3));
  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(4)) d4 (.clk(clk), .rst(rst), .bus(b4.master), .busy(busy4));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  logic        exp_ls;
  logic [31:0] dv;

  initial begin
    rst = 1'b0;
    b1.if_req = 0; b1.if_addr = 0; b1.ls_req = 0; b1.ls_we = 0; b1.ls_be = 0; b1.ls_addr = 0; b1.ls_wdata = 0; b1.mem_rdata = 0;
    b2.if_req = 0; b2.if_addr = 0; b2.ls_req = 0; b2.ls_we = 0; b2.ls_be = 0; b2.ls_addr = 0; b2.ls_wdata = 0; b2.mem_rdata = 0;
    b3.if_req = 0; b3.if_addr = 0; b3.ls_req = 0; b3.ls_we = 0; b3.ls_be = 0; b3.ls_addr = 0; b3.ls_wdata = 0; b3.mem_rdata = 0;
    b4.if_req = 0; b4.if_addr = 0; b4.ls_req = 0; b4.ls_we = 0; b4.ls_be = 0; b4.ls_addr = 0; b4.ls_wdata = 0; b4.mem_rdata = 0;
    repeat (2) @(negedge clk);

    // Reset state; a pending request is not granted while rst=0
    b1.if_req = 1; b1.if_addr = 32'h10; b1.mem_rdata = 32'h13;
    #1;
    chk("rst_gnt",    b1.if_gnt, 0);
    chk("rst_mem_en", b1.mem_en, 0);
    chk("rst_busy",   busy1, 0);
    chk("rst_addr",   b1.mem_addr, 0);
    chk("rst_wdata",  b1.mem_wdata, 0);
    chk("rst_rvalid", {b1.if_rvalid, b1.ls_rvalid}, 0);
    chk("rst_rdata",  {b1.if_rdata, b1.ls_rdata}, 0);

    // MEM_LAT=1 fetch
    @(negedge clk); rst = 1; #1;
    chk("t1_if_gnt", b1.if_gnt, 1);
    chk("t1_ls_gnt", b1.ls_gnt, 0);
    chk("t1_mem_en", b1.mem_en, 1);
    chk("t1_mem_we", b1.mem_we, 0);
    chk("t1_addr",   b1.mem_addr, 32'h10);
    chk("t1_busy0",  busy1, 0);
    @(negedge clk); b1.if_req = 0; #1;
    chk("t1_rvalid", b1.if_rvalid, 1);
    chk("t1_rdata",  b1.if_rdata, 32'h13);
    chk("t1_ls_rv",  b1.ls_rvalid, 0);
    chk("t1_busy1",  busy1, 1);
    chk("t1_en_off", b1.mem_en, 0);
    chk("t1_hold",   b1.mem_addr, 32'h10);
    @(negedge clk); b1.mem_rdata = 32'h0; #1;
    chk("t1_busy2",  busy1, 0);
    chk("t1_rv_off", b1.if_rvalid, 0);
    chk("t1_rhold",  b1.if_rdata, 32'h13);

    // MEM_LAT=1, both requesting continuously after reset: LS, IF, LS, IF
    @(negedge clk); rst = 0;
    @(negedge clk); rst = 1;
    b1.if_req = 1; b1.if_addr = 32'h20;
    b1.ls_req = 1; b1.ls_we = 0; b1.ls_addr = 32'h40;
    for (int i = 0; i < 4; i++) begin
      exp_ls = (i % 2 == 0);
      dv = 32'hA0 + 32'(i);
      #1;
      chk("t3_ls_gnt", b1.ls_gnt, exp_ls);
      chk("t3_if_gnt", b1.if_gnt, !exp_ls);
      chk("t3_addr",   b1.mem_addr, exp_ls ? 32'h40 : 32'h20);
      @(negedge clk); b1.mem_rdata = dv; #1;
      chk("t3_ls_rv",  b1.ls_rvalid, exp_ls);
      chk("t3_if_rv",  b1.if_rvalid, !exp_ls);
      chk("t3_rdata",  exp_ls ? b1.ls_rdata : b1.if_rdata, dv);
      @(negedge clk);
    end
    b1.if_req = 0; b1.ls_req = 0; #1;
    chk("t3_done", busy1, 0);

    // MEM_LAT=3 store, then an IF request raised during WAIT
    @(negedge clk);
    b3.ls_req = 1; b3.ls_we = 1; b3.ls_be = 4'b0011; b3.ls_addr = 32'h100;
    b3.ls_wdata = 32'hDEADBEEF; b3.mem_rdata = 32'h55;
    #1;
    chk("t2_ls_gnt", b3.ls_gnt, 1);
    chk("t2_mem_we", b3.mem_we, 4'b0011);
    chk("t2_wdata",  b3.mem_wdata, 32'hDEADBEEF);
    chk("t2_addr",   b3.mem_addr, 32'h100);
    @(negedge clk); b3.ls_req = 0; b3.if_req = 1; b3.if_addr = 32'h200; #1;
    chk("t2_gnt_w1", {b3.if_gnt, b3.ls_gnt, b3.mem_en}, 0);
    chk("t2_we_w1",  b3.mem_we, 0);
    chk("t2_busy",   busy3, 1);
    @(negedge clk); #1;
    chk("t2_gnt_w2", {b3.if_gnt, b3.ls_gnt, b3.mem_en}, 0);
    chk("t2_rv_w2",  b3.ls_rvalid, 0);
    @(negedge clk); #1;
    chk("t2_gnt_r",  {b3.if_gnt, b3.ls_gnt}, 0);
    chk("t2_ls_rv",  b3.ls_rvalid, 1);
    chk("t2_rdata0", b3.ls_rdata, 0);
    chk("t2_if_rv",  b3.if_rvalid, 0);
    @(negedge clk); #1;
    chk("t2_if_gnt", b3.if_gnt, 1);
    chk("t2_if_adr", b3.mem_addr, 32'h200);
    chk("t2_wd_if",  b3.mem_we, 0);
    @(negedge clk); b3.if_req = 0;
    @(negedge clk);
    @(negedge clk); b3.mem_rdata = 32'h77; #1;
    chk("t2_if_rv2", b3.if_rvalid, 1);
    chk("t2_if_rd",  b3.if_rdata, 32'h77);

    // MEM_LAT=3 load; IF rises in WAIT and is granted in the IDLE after RESP
    @(negedge clk);
    b3.ls_req = 1; b3.ls_we = 0; b3.ls_be = 4'b0000; b3.ls_addr = 32'h300; #1;
    chk("t4_ls_gnt", b3.ls_gnt, 1);
    chk("t4_we0",    b3.mem_we, 0);
    @(negedge clk); b3.ls_req = 0; b3.if_req = 1; b3.if_addr = 32'h400; #1;
    chk("t4_if_w1",  b3.if_gnt, 0);
    @(negedge clk); #1;
    chk("t4_if_w2",  b3.if_gnt, 0);
    @(negedge clk); b3.mem_rdata = 32'h99; #1;
    chk("t4_ls_rv",  b3.ls_rvalid, 1);
    chk("t4_ls_rd",  b3.ls_rdata, 32'h99);
    chk("t4_if_r",   b3.if_gnt, 0);
    @(negedge clk); #1;
    chk("t4_if_gnt", b3.if_gnt, 1);
    chk("t4_if_adr", b3.mem_addr, 32'h400);
    chk("t4_ls_hld", b3.ls_rdata, 32'h99);
    @(negedge clk); b3.if_req = 0;

    // MEM_LAT=4: reset during WAIT discards the transaction
    @(negedge clk);
    b4.ls_req = 1; b4.ls_we = 0; b4.ls_addr = 32'h500; b4.mem_rdata = 32'h66; #1;
    chk("t5_ls_gnt", b4.ls_gnt, 1);
    @(negedge clk); b4.ls_req = 0; #1;
    chk("t5_busy",   busy4, 1);
    rst = 0;
    @(negedge clk);
    b4.if_req = 1; b4.if_addr = 32'h510; b4.ls_req = 1; b4.ls_addr = 32'h520; #1;
    chk("t5_busy0",  busy4, 0);
    chk("t5_rv0",    b4.ls_rvalid, 0);
    chk("t5_gated",  {b4.if_gnt, b4.ls_gnt, b4.mem_en}, 0);
    @(negedge clk); rst = 1; #1;
    chk("t5_ls_1st", b4.ls_gnt, 1);
    chk("t5_if_no",  b4.if_gnt, 0);
    chk("t5_addr",   b4.mem_addr, 32'h520);
    @(negedge clk); b4.ls_req = 0; #1;
    chk("t5_rv_a",   b4.ls_rvalid, 0);
    @(negedge clk); #1;
    chk("t5_rv_b",   b4.ls_rvalid, 0);
    @(negedge clk); #1;
    chk("t5_rv_c",   b4.ls_rvalid, 0);
    @(negedge clk); #1;
    chk("t5_rv_new", b4.ls_rvalid, 1);
    chk("t5_rd_new", b4.ls_rdata, 32'h66);
    @(negedge clk); #1;
    chk("t5_if_nxt", b4.if_gnt, 1);
    @(negedge clk); b4.if_req = 0;

    // MEM_LAT=2: ls_req dropped right after the grant
    @(negedge clk);
    b2.ls_req = 1; b2.ls_we = 0; b2.ls_addr = 32'h600; b2.mem_rdata = 32'h0; #1;
    chk("t6_ls_gnt", b2.ls_gnt, 1);
    @(negedge clk); b2.ls_req = 0; #1;
    chk("t6_rv_w",   b2.ls_rvalid, 0);
    @(negedge clk); b2.mem_rdata = 32'h12345678; #1;
    chk("t6_rv",     b2.ls_rvalid, 1);
    chk("t6_rd",     b2.ls_rdata, 32'h12345678);
    @(negedge clk); b2.mem_rdata = 32'h0; #1;
    chk("t6_rv_off", b2.ls_rvalid, 0);
    chk("t6_rd_hld", b2.ls_rdata, 32'h12345678);
    chk("t6_busy",   busy2, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Arbitrates one single-port unified instruction/data memory between two requesters inside cpu_top: the fetch unit (IF) and the load/store unit (LS).
- Each requester uses a req/gnt handshake. The arbiter drives the memory command and returns read data after a fixed memory latency.
- Only one transaction is outstanding at a time, so the arbiter is the sole sequencer of the memory port.

Parameters:
- ADDR_W, 32, address width of requesters and memory.
- DATA_W, 32, data width. Byte-enable width is DATA_W/8.
- MEM_LAT, 1, cycles from the memory command cycle to mem_rdata valid. Legal range 1..8.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, synchronous, active-low.
- if_req  in  1  fetch request; held with if_addr stable until if_gnt.
- if_addr  in  ADDR_W  fetch address.
- if_gnt  out  1  fetch request accepted this cycle.
- if_rvalid  out  1  one-cycle pulse; if_rdata valid.
- if_rdata  out  DATA_W  fetch read data.
- ls_req  in  1  load/store request; held with all ls_* fields stable until ls_gnt.
- ls_we  in  1  1 = store, 0 = load.
- ls_be  in  DATA_W/8  store byte enables.
- ls_addr  in  ADDR_W  load/store address.
- ls_wdata  in  DATA_W  store data.
- ls_gnt  out  1  load/store request accepted this cycle.
- ls_rvalid  out  1  one-cycle pulse: load data valid, or store completion.
- ls_rdata  out  DATA_W  load data; 0 for stores.
- mem_en  out  1  memory command strobe.
- mem_we  out  DATA_W/8  per-byte write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data, valid MEM_LAT cycles after mem_en.
- busy  out  1  a transaction is outstanding (state != IDLE).

Behaviour:
- FSM states are IDLE, WAIT and RESP.
- IDLE:
  - With no request, nothing happens.
  - With one or both requests, a winner is picked. In the same cycle the arbiter asserts the winner's gnt combinationally and drives mem_en=1, mem_addr and mem_wdata from the winner. mem_we = ls_be when LS wins with ls_we=1, otherwise 0.
  - Next state is WAIT when MEM_LAT>1, else RESP.
- Arbitration: round-robin with a 1-bit last-winner pointer.
  - When both request, the requester that did not win last goes first.
  - When only one requests, it wins regardless of the pointer.
  - The pointer updates on each grant.
  - After reset the pointer favours LS.
- WAIT: a down-counter loaded with MEM_LAT-2 at grant. Move to RESP when it reaches 0. The counter is $clog2(8) = 3 bits.
- RESP:
  - Pulse the owner's rvalid for 1 cycle.
  - Owner rdata is mem_rdata sampled this cycle. Reads only; stores pulse ls_rvalid with ls_rdata=0.
  - Next state is IDLE.
- Latency: grant at cycle T, rvalid at T+MEM_LAT, next grant no earlier than T+MEM_LAT+1. Peak throughput is 1 transaction per MEM_LAT+1 cycles.
- Outside the grant cycle: mem_en=0, mem_we=0, mem_addr and mem_wdata hold their last value. gnt is never asserted outside IDLE.
- rdata outputs are registered and hold their value between rvalid pulses. The non-owner's rvalid stays 0.
- Simultaneous events:
  - A request that rises during WAIT/RESP waits; it is not dropped.
  - If the owner deasserts req after gnt, the transaction still completes.
- Reset (rst=0 at a clock edge), including mid-transaction:
  - state=IDLE, pointer=LS, counter=0, if_rvalid=ls_rvalid=0, if_rdata=ls_rdata=0, mem_addr=mem_wdata=0, busy=0.
  - Any outstanding response is discarded.
  - gnt and mem_en are gated to 0 while rst=0.
- Addresses pass through unmodified; no alignment checking.

Decomposition:
- Package mem_arb_pkg:
  - FSM state encoding (IDLE=2'd0, WAIT=2'd1, RESP=2'd2).
  - Owner IDs OWN_IF=1'b0 and OWN_LS=1'b1.
  - MEM_LAT_MAX=8.
- One sub-module: rr_pick2, the combinational 2-way round-robin picker (inputs req[1:0] and last; outputs grant-valid and winner ID). The pointer register stays in mem_arbiter.

Test Plan:
- MEM_LAT=1, if_req alone at 0x00000010 with mem_rdata=0x00000013 → if_gnt and mem_en=1, mem_we=0, mem_addr=0x10 in cycle T; if_rvalid=1 and if_rdata=0x13 at T+1; busy=1 only at T+1.
- MEM_LAT=3, ls store addr=0x100, be=4'b0011, wdata=0xDEADBEEF → cycle T: mem_we=4'b0011, mem_wdata=0xDEADBEEF; ls_rvalid at T+3 with ls_rdata=0; no gnt during T+1..T+3.
- Both requests held continuously after reset → grants alternate LS, IF, LS, IF; 4 transactions complete in 4*(MEM_LAT+1) cycles; each rvalid is routed only to its owner.
- if_req rises during WAIT of an LS load → if_gnt first asserted in the IDLE cycle after LS RESP; if_addr sampled then.
- rst=0 applied in WAIT with MEM_LAT=4 → next cycle state IDLE, busy=0, no rvalid pulse ever emitted for that transaction; after release, a pending IF and LS pair is granted LS first.
- ls_req dropped the cycle after ls_gnt on a load with MEM_LAT=2 → ls_rvalid still pulses at T+2 carrying mem_rdata.
